ir: RTL and testbench
=====================

// Module: ir
//
// PURPOSE
//   Instruction register of the image-downsampling processor datapath.
//   - Captures the 8-bit instruction word from instruction memory on every rising clock edge.
//   - Presents the full word to the control unit / decoder.
//   - Presents the low nibble separately as a 4-bit immediate operand.
//   - Sits between instruction memory and the control unit, next to the PC.
//
// PARAMETERS
//   INSTR_W  8  width of instruction word (ir_in, ir_out)
//   IMM_W    4  width of immediate field; taken from bits [IMM_W-1:0] of the word; IMM_W <= INSTR_W
//
// PORTS
//   clk        input   1        single system clock, rising-edge active
//   RST        input   1        synchronous, active-high reset
//   ir_in      input   INSTR_W  instruction word from instruction memory
//   immediate  output  IMM_W    immediate operand = low IMM_W bits of the held instruction
//   ir_out     output  INSTR_W  held instruction word to the control unit
//   Port order for positional instantiation: clk, RST, ir_in, immediate, ir_out.
//
// BEHAVIOUR
//   - One clock: clk. Reset RST is synchronous and active-high; it is sampled only on a rising clk edge.
//   - Reset: on a rising clk edge with RST=1:
//     - ir_out becomes 0.
//     - immediate becomes 0.
//     - RST has priority over loading.
//   - Load: on a rising clk edge with RST=0:
//     - ir_out <= ir_in. The register loads every cycle; there is no enable.
//   - immediate:
//     - Combinational slice ir_out[IMM_W-1:0].
//     - Always consistent with ir_out in the same cycle; no extra latency.
//     - Zero-extended field; no sign extension.
//   - Latency: exactly 1 clock from ir_in to both outputs.
//   - Outputs change only on rising clk edges; ir_in changes between edges have no effect.
//   - Power-up value before the first reset edge is undefined (X allowed in simulation).
//   - Reset mid-operation: a single RST=1 edge clears both outputs, regardless of the value on ir_in that cycle.
//     The first edge after RST falls loads the current ir_in.
//   - No handshake, no state machine, no arithmetic. Upper bits [INSTR_W-1:IMM_W] are passed through unmodified in ir_out.
//
// STRUCTURE
//   - Shared package/header (processor-wide constants):
//     - INSTR_W = 8, IMM_W = 4.
//     - Opcode field position: [INSTR_W-1:IMM_W].
//     - Immediate field position: [IMM_W-1:0].
//   - No sub-module: one always @(posedge clk) register with synchronous reset, plus one continuous assign for immediate.
//
// TESTING
//   1. clk toggling, RST=1 for one edge with ir_in=8'hFF
//      -> ir_out=8'h00, immediate=4'h0 after that edge.
//   2. RST=0, ir_in=8'b00000001
//      -> after next rising edge ir_out=8'h01, immediate=4'h1.
//   3. ir_in=8'b00001000
//      -> after next edge ir_out=8'h08, immediate=4'h8.
//   4. ir_in=8'b10000011
//      -> after next edge ir_out=8'h83, immediate=4'h3; upper nibble is not visible on immediate.
//   5. ir_in changed mid-cycle (between edges)
//      -> outputs unchanged until the following rising edge; 1-cycle latency checked edge by edge.
//   6. With ir_out=8'h83, assert RST=1 while ir_in=8'h5A
//      -> outputs clear to 0 at that edge.
//      Deassert RST -> next edge loads 8'h5A, immediate=4'hA.

Source files
------------

// File: rtl/ir_pkg.sv
// Processor-wide instruction format constants shared by the datapath blocks.
// The opcode sits in the upper bits and the immediate in the low bits of each word.
package ir_pkg;

  localparam int INSTR_W = 8;
  localparam int IMM_W   = 4;

  // Field boundaries of an instruction word.
  localparam int OPC_MSB = INSTR_W - 1;
  localparam int OPC_LSB = IMM_W;
  localparam int IMM_MSB = IMM_W - 1;
  localparam int IMM_LSB = 0;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [IMM_W-1:0]   imm_t;

  // Zero-extended immediate field of a word.
  function automatic imm_t imm_of(input instr_t w);
    return w[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/ir.sv
// Instruction register: captures the instruction word every clock edge.
// The immediate output is the low field of the held word, with no added latency.
module ir
  import ir_pkg::*;
#(
  parameter int INSTR_W = ir_pkg::INSTR_W,
  parameter int IMM_W   = ir_pkg::IMM_W
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [INSTR_W-1:0] ir_in,
  output logic [IMM_W-1:0]   immediate,
  output logic [INSTR_W-1:0] ir_out
);

  // Loads unconditionally; reset wins over the incoming word.
  always_ff @(posedge clk) begin
    if (RST) ir_out <= '0;
    else     ir_out <= ir_in;
  end

  assign immediate = ir_out[IMM_W-1:0];

endmodule

// File: tb/tb_ir.sv
// Bench for the instruction register: directed cases and random traffic
// checked against a cycle-level reference of "output = last sampled word or zero on reset".
module tb_ir;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] ir_in;
  logic [3:0] immediate;
  logic [7:0] ir_out;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_ir;

  ir dut (
    .clk      (clk),
    .RST      (RST),
    .ir_in    (ir_in),
    .immediate(immediate),
    .ir_out   (ir_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle, update the reference at the edge, check both outputs after it.
  task automatic cycle(input logic rst_v, input logic [7:0] in_v, input string tag);
    RST   = rst_v;
    ir_in = in_v;
    @(posedge clk);
    exp_ir = rst_v ? 0 : int'(in_v);
    #2;
    chk({tag, "_out"}, 32'(ir_out), exp_ir);
    chk({tag, "_imm"}, 32'(immediate), exp_ir % 16);
  endtask

  initial begin
    RST   = 1'b0;
    ir_in = 8'h00;
    #2;

    cycle(1'b1, 8'hFF, "reset");
    cycle(1'b0, 8'h01, "load01");
    cycle(1'b0, 8'h08, "load08");
    cycle(1'b0, 8'h83, "load83");

    // Input changes between edges must not reach the outputs.
    ir_in = 8'h3C;
    #3;
    chk("midcyc_out", 32'(ir_out), 32'h83);
    chk("midcyc_imm", 32'(immediate), 32'h3);
    ir_in = 8'hC7;
    #1;
    chk("midcyc2_out", 32'(ir_out), 32'h83);
    cycle(1'b0, 8'hC7, "after_mid");
    cycle(1'b0, 8'h83, "reload83");

    cycle(1'b1, 8'h5A, "rst_mid");
    cycle(1'b0, 8'h5A, "post_rst");

    for (int i = 0; i < 200; i++) begin
      logic       r;
      logic [7:0] v;
      r = ($urandom_range(0, 7) == 0);
      v = 8'($urandom);
      cycle(r, v, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
